audio_pdm_tx: RTL and testbench
===============================

// Module: audio_pdm_tx
// PURPOSE
//  Playback counterpart of the mic capture path: accepts 16-bit signed PCM samples with a valid strobe (same format as data_mic/data_mic_valid),
//  buffers them in a small FIFO, and plays one sample per audio frame through a first-order sigma-delta modulator.
//  Drives the board mono audio jack (PWM/PDM pin plus amplifier shutdown pin). Sits between the audio DSP/loopback logic and the top-level pins.
// PARAMETERS
//  CLK_DIV     40   clk_i cycles per PDM output bit (100 MHz / 40 = 2.5 MHz bit rate)
//  OSR         52   PDM bits per audio sample (2.5 MHz / 52 ~= 48.08 kHz frame rate)
//  FIFO_DEPTH  4    sample FIFO entries, power of 2, >= 2
// PORTS
//  clk_i           in   1   system clock, 100 MHz
//  rst_i           in   1   reset, asynchronous, active-high
//  data_spk        in   16  PCM sample, signed two's complement
//  data_spk_valid  in   1   sample strobe; push when data_spk_valid && data_spk_ready
//  data_spk_ready  out  1   FIFO not full
//  enable_i        in   1   playback enable
//  pwm_audio_o     out  1   PDM bitstream to audio low-pass filter
//  pwm_sd_o        out  1   amplifier enable (1 = on), registered copy of enable_i
//  underrun_o      out  1   one-cycle pulse: frame boundary found FIFO empty
//  fifo_level_o    out  log2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async): FIFO empty, counters 0, acc 0, cur_sample 16'h8000; outputs pwm_audio_o=0, pwm_sd_o=0, underrun_o=0, data_spk_ready=1, fifo_level_o=0.
//  FIFO: push on valid&&ready; data_spk_ready = !full (combinational from occupancy). Valid while not ready is ignored (no drop flag).
//   Push and pop in the same cycle: allowed when neither empty nor full; level unchanged. No bypass: pop on an empty FIFO is an underrun even if a push occurs that cycle.
//  Timing: bit_cnt counts 0..CLK_DIV-1; bit_tick when bit_cnt==CLK_DIV-1. frame_cnt advances on bit_tick, 0..OSR-1; frame_tick = bit_tick && frame_cnt==OSR-1.
//  Frame start (frame_tick): pop FIFO into cur_sample as data ^ 16'h8000 (offset binary).
//   If FIFO is empty: cur_sample <= 16'h8000 (silence, 50% duty) and underrun_o pulses for exactly that cycle.
//  Modulator (on every bit_tick): acc[16:0] <= {1'b0, acc[15:0]} + {1'b0, cur_sample}; pwm_audio_o <= carry (bit 16 of the sum). Output is registered, no glitches.
//   A sample popped on frame_tick is first used on the next bit_tick (CLK_DIV cycles later).
//   Output ones density per frame ~= cur_sample/65536 * OSR.
//  enable_i=0: bit_cnt, frame_cnt and acc are held at 0; pwm_audio_o=0; no pops and no underrun pulses. FIFO keeps its contents and still accepts pushes.
//   pwm_sd_o follows enable_i with 1 cycle of latency.
//  enable_i 0->1: the counters start from 0, so the first frame_tick comes CLK_DIV*OSR cycles later; cur_sample keeps its last value until then.
//  Async reset mid-frame: all state returns to its reset value immediately; FIFO contents are discarded.
// TESTING
//  1 Reset, enable=1, FIFO never fed -> underrun_o pulses every 2080 clk; pwm_audio_o has 26 ones per 52-bit frame; data_spk_ready=1.
//  2 Push 16'h0000 and refill each frame -> 26 ones/frame in steady state; underrun_o stays 0; fifo_level_o holds between 0 and FIFO_DEPTH.
//  3 Push 16'h7FFF continuously -> 51 or 52 ones/frame; push 16'h8000 -> 0 ones/frame after the next frame boundary.
//  4 Push 5 samples back-to-back with enable=0 -> 4 accepted, data_spk_ready=0 after the 4th, 5th ignored, fifo_level_o=4, pwm_audio_o=0, pwm_sd_o=0.
//  5 At fifo_level_o=2, push on the same cycle as frame_tick -> level stays 2; pop order is FIFO order (check with sequence 16'h1000, 16'h2000, 16'h3000).
//  6 Assert rst_i mid-frame while FIFO holds 3 -> outputs go to reset values without a clock edge; fifo_level_o=0; first underrun_o 2080 clk after release.

Source files
------------

// File: rtl/audio_pdm_tx.sv
// Mono PCM playback: sample FIFO feeding a first-order sigma-delta modulator
// that produces one PDM bit every CLK_DIV clocks and one audio frame every OSR bits.
module audio_pdm_tx #(
  parameter int CLK_DIV    = 40,
  parameter int OSR        = 52,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 data_spk,
  input  logic                        data_spk_valid,
  output logic                        data_spk_ready,
  input  logic                        enable_i,
  output logic                        pwm_audio_o,
  output logic                        pwm_sd_o,
  output logic                        underrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam int FW = $clog2(OSR);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(OSR - 1);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] frame_cnt;
  logic [15:0]   acc;
  logic [15:0]   cur_sample;
  logic [16:0]   sum;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bit_tick;
  logic          frame_tick;

  assign full           = (level == FULL_LEVEL);
  assign empty          = (level == '0);
  assign push           = data_spk_valid && !full;
  assign bit_tick       = enable_i && (bit_cnt == BIT_LAST);
  assign frame_tick     = bit_tick && (frame_cnt == FRAME_LAST);
  // An empty FIFO at a frame boundary is an underrun even if a push lands on the same edge.
  assign pop            = frame_tick && !empty;
  assign sum            = {1'b0, acc} + {1'b0, cur_sample};
  assign data_spk_ready = !full;
  assign fifo_level_o   = level;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_spk;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Bit/frame timing and modulator; disabling parks everything at zero so
  // re-enabling always starts a full frame from scratch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      acc         <= '0;
      cur_sample  <= 16'h8000;
      pwm_audio_o <= 1'b0;
      pwm_sd_o    <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      pwm_sd_o   <= enable_i;
      underrun_o <= frame_tick && empty;
      if (!enable_i) begin
        bit_cnt     <= '0;
        frame_cnt   <= '0;
        acc         <= '0;
        pwm_audio_o <= 1'b0;
      end else begin
        bit_cnt <= bit_tick ? '0 : bit_cnt + BW'(1);
        if (bit_tick) begin
          frame_cnt   <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
          acc         <= sum[15:0];
          pwm_audio_o <= sum[16];
        end
      end
      // Stored as offset binary; the modulator first sees it on the next bit tick.
      if (frame_tick) begin
        cur_sample <= empty ? 16'h8000 : (mem[rd_ptr] ^ 16'h8000);
      end
    end
  end

endmodule

// File: tb/tb_audio_pdm_tx.sv
// Self-checking bench for audio_pdm_tx: a cycle monitor with a sample scoreboard
// and modulator reference, plus directed steps for the playback scenarios.
module tb_audio_pdm_tx;

  localparam int CLK_DIV = 40;
  localparam int OSR     = 52;
  localparam int FRAME   = CLK_DIV * OSR;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_spk = 16'h0000;
  logic        data_spk_valid = 1'b0;
  logic        data_spk_ready;
  logic        enable_i = 1'b0;
  logic        pwm_audio_o;
  logic        pwm_sd_o;
  logic        underrun_o;
  logic [2:0]  fifo_level_o;

  int errors = 0;
  int checks = 0;

  logic [15:0] sb [$];
  logic [15:0] acc_m = 16'h0000;
  logic [15:0] cur_m = 16'h8000;
  logic [16:0] sum_m;
  logic        pwm_m = 1'b0;
  logic        ur_m = 1'b0;
  logic        sd_m = 1'b0;
  logic        full_pre;
  int          cyc = 0;
  int          ones_acc = 0;
  int          last_ones = -1;
  int          frames_done = 0;
  int          ur_obs = 0;
  int          since_rel = 0;
  int          first_ur = 0;

  audio_pdm_tx #(.CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_spk       (data_spk),
    .data_spk_valid (data_spk_valid),
    .data_spk_ready (data_spk_ready),
    .enable_i       (enable_i),
    .pwm_audio_o    (pwm_audio_o),
    .pwm_sd_o       (pwm_sd_o),
    .underrun_o     (underrun_o),
    .fifo_level_o   (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge; holds valid for exactly one rising edge.
  task automatic applyStimulus(input logic [15:0] d);
    data_spk       = d;
    data_spk_valid = 1'b1;
    @(negedge clk_i);
    data_spk_valid = 1'b0;
  endtask

  task automatic doReset(input logic en_after);
    @(negedge clk_i);
    rst_i          = 1'b1;
    enable_i       = 1'b0;
    data_spk_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i    = 1'b0;
    enable_i = en_after;
  endtask

  task automatic waitFrames(input int n);
    int target;
    int budget;
    target = frames_done + n;
    budget = n * FRAME + 200;
    while (frames_done < target && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    checkRange("frame_wait", frames_done, target, target);
  endtask

  // Reference: scoreboard of accepted samples, popped at each frame boundary,
  // feeding a model of the modulator; every output is compared each cycle.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      sb.delete();
      cyc       = 0;
      acc_m     = 16'h0000;
      cur_m     = 16'h8000;
      pwm_m     = 1'b0;
      ur_m      = 1'b0;
      sd_m      = 1'b0;
      ones_acc  = 0;
      since_rel = 0;
      first_ur  = 0;
    end else begin
      full_pre = (sb.size() == 4);
      sd_m     = enable_i;
      ur_m     = 1'b0;
      since_rel++;
      if (!enable_i) begin
        cyc      = 0;
        acc_m    = 16'h0000;
        pwm_m    = 1'b0;
        ones_acc = 0;
      end else begin
        cyc++;
        if (cyc % CLK_DIV == 0) begin
          sum_m = {1'b0, acc_m} + {1'b0, cur_m};
          pwm_m = sum_m[16];
          acc_m = sum_m[15:0];
          ones_acc += int'(pwm_audio_o);
          if (cyc % FRAME == 0) begin
            last_ones = ones_acc;
            ones_acc  = 0;
            frames_done++;
            if (sb.size() > 0) begin
              cur_m = sb.pop_front() ^ 16'h8000;
            end else begin
              cur_m = 16'h8000;
              ur_m  = 1'b1;
            end
          end
        end
      end
      if (data_spk_valid && !full_pre) sb.push_back(data_spk);
      if (underrun_o === 1'b1) begin
        ur_obs++;
        if (first_ur == 0) first_ur = since_rel;
      end
    end
    checkOutput("pwm_audio", 32'(pwm_audio_o), 32'(pwm_m));
    checkOutput("underrun", 32'(underrun_o), 32'(ur_m));
    checkOutput("pwm_sd", 32'(pwm_sd_o), 32'(sd_m));
    checkOutput("fifo_level", 32'(fifo_level_o), 32'(sb.size()));
    checkOutput("ready", 32'(data_spk_ready), 32'(sb.size() != 4));
  end

  initial begin
    int ur0;
    int budget;

    // Reset values, then free-running with nothing queued.
    #1;
    checkOutput("rst_pwm", 32'(pwm_audio_o), 0);
    checkOutput("rst_sd", 32'(pwm_sd_o), 0);
    checkOutput("rst_underrun", 32'(underrun_o), 0);
    checkOutput("rst_ready", 32'(data_spk_ready), 1);
    checkOutput("rst_level", 32'(fifo_level_o), 0);
    $display("[TB] step 1: starved playback");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i    = 1'b0;
    enable_i = 1'b1;
    waitFrames(3);
    checkOutput("starve_underruns", ur_obs, 3);
    checkOutput("starve_first_ur", first_ur, FRAME);
    checkOutput("starve_ones", last_ones, 26);
    checkOutput("starve_ready", 32'(data_spk_ready), 1);

    // Silence fed one sample per frame: no underruns, half duty.
    $display("[TB] step 2: fed silence");
    ur0 = ur_obs;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'h0000);
      waitFrames(1);
    end
    checkOutput("silence_no_ur", ur_obs, ur0);
    checkOutput("silence_ones", last_ones, 26);

    // Full scale positive then full scale negative.
    $display("[TB] step 3: full scale");
    for (int i = 0; i < 4; i++) applyStimulus(16'h7FFF);
    waitFrames(1);
    applyStimulus(16'h7FFF);
    waitFrames(1);
    checkRange("max_ones", last_ones, 51, 52);
    waitFrames(4);
    applyStimulus(16'h8000);
    applyStimulus(16'h8000);
    waitFrames(2);
    checkOutput("min_ones", last_ones, 0);

    // Disabled: FIFO fills to depth, extra sample ignored, outputs quiet.
    $display("[TB] step 4: disabled fill");
    doReset(1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(16'(i));
    checkOutput("fill_level", 32'(fifo_level_o), 4);
    checkOutput("fill_ready", 32'(data_spk_ready), 0);
    checkOutput("fill_pwm", 32'(pwm_audio_o), 0);
    checkOutput("fill_sd", 32'(pwm_sd_o), 0);

    // Push coinciding with a frame pop keeps the level; order is FIFO order.
    $display("[TB] step 5: simultaneous push/pop");
    doReset(1'b0);
    applyStimulus(16'h1000);
    applyStimulus(16'h2000);
    checkOutput("pre_level", 32'(fifo_level_o), 2);
    enable_i = 1'b1;
    budget = FRAME + 50;
    while (cyc != FRAME - 1 && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    checkOutput("align_cyc", cyc, FRAME - 1);
    applyStimulus(16'h3000);
    checkOutput("same_cycle_level", 32'(fifo_level_o), 2);
    waitFrames(1);
    checkRange("order_1000", last_ones, 29, 30);
    waitFrames(1);
    checkRange("order_2000", last_ones, 32, 33);
    waitFrames(1);
    checkRange("order_3000", last_ones, 35, 36);

    // Asynchronous reset mid-frame with three samples queued.
    $display("[TB] step 6: async reset");
    applyStimulus(16'h4000);
    applyStimulus(16'h5000);
    applyStimulus(16'h6000);
    repeat (300) @(negedge clk_i);
    budget = 4 * CLK_DIV;
    while (pwm_audio_o !== 1'b1 && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    checkOutput("pre_rst_pwm", 32'(pwm_audio_o), 1);
    checkOutput("pre_rst_level", 32'(fifo_level_o), 3);
    #2;
    rst_i    = 1'b1;
    enable_i = 1'b0;
    #1;
    checkOutput("async_pwm", 32'(pwm_audio_o), 0);
    checkOutput("async_sd", 32'(pwm_sd_o), 0);
    checkOutput("async_underrun", 32'(underrun_o), 0);
    checkOutput("async_ready", 32'(data_spk_ready), 1);
    checkOutput("async_level", 32'(fifo_level_o), 0);
    repeat (3) @(negedge clk_i);
    rst_i    = 1'b0;
    enable_i = 1'b1;
    waitFrames(1);
    checkOutput("post_rst_first_ur", first_ur, FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
